// File: rtl/trans_ingress.sv
// -----------------------------------------------------------------------------
// trans_ingress
//
// Upstream stage of trans_validator. It collects the 32-bit transaction word
// stream into 128-bit transactions, queues them in a circular FIFO, and
// presents the FIFO head on the validator's data_i/valid_i/ack_o handshake.
// The head is held stable until the validator has sampled it.
//
// Word order is MSB first:
//   word 0 -> [127:96], word 1 -> [95:64], word 2 -> [63:32], word 3 -> [31:0]
// Field map:
//   sender [127:80], receiver [79:32], amount [31:10], block-start [9],
//   reserved [8:0]
//
// Optional feature macro: TRANS_INGRESS_FILTER_EN
//   When defined, a completed transaction with sender == receiver or
//   amount == 0 is dropped instead of queued, and filt_drop_o pulses.
//   When undefined, every completed transaction is queued and filt_drop_o
//   is tied low.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   word_i        in   32-bit transaction word
//   word_valid_i  in   word_i valid
//   word_sof_i    in   word_i is word 0 of a transaction
//   word_ready_o  out  a word can be accepted (level_o < DEPTH)
//   data_o        out  FIFO head (validator data_i)
//   valid_o       out  head valid, level_o != 0 (validator valid_i)
//   ack_i         in   validator ack_o
//   level_o       out  FIFO occupancy
//   frame_err_o   out  one-cycle pulse on a framing error
//   filt_drop_o   out  one-cycle pulse when a transaction is filtered
// -----------------------------------------------------------------------------
module trans_ingress #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   word_i,
    input  logic          word_valid_i,
    input  logic          word_sof_i,
    output logic          word_ready_o,
    output logic [127:0]  data_o,
    output logic          valid_o,
    input  logic          ack_i,
    output logic [LW-1:0] level_o,
    output logic          frame_err_o,
    output logic          filt_drop_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);

    // Assembler state: index of the next expected word plus words 0..2.
    logic [1:0]   idx_q, idx_d;
    logic [95:0]  asm_q, asm_d;

    // FIFO state.
    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Validator sampling tracker: the head has been visible for at least one
    // full cycle since the last pop, so an ack now refers to it.
    logic vq_q, vq_d;

    logic frame_err_q, frame_err_d;

    logic         word_acc;
    logic         txn_done;
    logic         filter_hit;
    logic         push;
    logic         pop;
    logic [127:0] txn_data;

    // ------------------------------------------------------------------
    // Handshake status, derived purely from registered occupancy
    // ------------------------------------------------------------------
    always_comb begin
        word_ready_o = (level_q < DEPTH_LV);
        valid_o      = (level_q != '0);
        level_o      = level_q;
        data_o       = mem_q[rd_ptr_q];
        frame_err_o  = frame_err_q;
    end

    assign word_acc = word_valid_i && word_ready_o;
    // Word 3 arrives live on word_i; the first three are held in asm_q.
    assign txn_data = {asm_q, word_i};

    // ------------------------------------------------------------------
    // Framing / assembly
    // ------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        asm_d       = asm_q;
        frame_err_d = 1'b0;
        txn_done    = 1'b0;
        if (word_acc) begin
            if (word_sof_i) begin
                // A start-of-frame always restarts assembly; an interrupted
                // partial transaction is abandoned and flagged.
                if (idx_q != 2'd0) begin
                    frame_err_d = 1'b1;
                end
                asm_d[95:64] = word_i;
                idx_d        = 2'd1;
            end else begin
                unique case (idx_q)
                    2'd0: begin
                        // Continuation word with no frame in progress.
                        frame_err_d = 1'b1;
                    end
                    2'd1: begin
                        asm_d[63:32] = word_i;
                        idx_d        = 2'd2;
                    end
                    2'd2: begin
                        asm_d[31:0] = word_i;
                        idx_d       = 2'd3;
                    end
                    default: begin
                        txn_done = 1'b1;
                        idx_d    = 2'd0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional content filter
    // ------------------------------------------------------------------
`ifdef TRANS_INGRESS_FILTER_EN
    logic filt_drop_q, filt_drop_d;

    assign filter_hit  = (txn_data[127:80] == txn_data[79:32]) ||
                         (txn_data[31:10] == 22'd0);
    assign filt_drop_d = txn_done && filter_hit;
    assign filt_drop_o = filt_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_drop_q <= 1'b0;
        end else begin
            filt_drop_q <= filt_drop_d;
        end
    end
`else
    assign filter_hit  = 1'b0;
    assign filt_drop_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    // A push can only happen while not full because word_acc requires
    // word_ready_o. A pop needs vq_q, which implies a non-empty FIFO.
    assign push = txn_done && !filter_hit;
    assign pop  = ack_i && vq_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Clearing on pop stops a single sampling event from popping twice.
        vq_d = valid_o && !pop;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 2'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            vq_q        <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            vq_q        <= vq_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Data storage (contents are meaningless until validated by level_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
        if (push) begin
            // When not empty the write slot differs from the read slot, so
            // the head only changes here when pushing into an empty FIFO.
            mem_q[wr_ptr_q] <= txn_data;
        end
    end

endmodule
